fetch_ctrl: RTL and testbench

Pipeline control unit that drives the fetch stage's control inputs (`pc_en`, `stall_en`, `jmp_bch_en`, `jmp_bch_tgt`) and the IF/ID and ID/EX register controls. It consumes branch resolution from EX, load-use operand information from ID/EX, and the data-memory busy flag. From these it sequences redirects, wrong-path squashing, load-use bubbles and memory-wait freezes. It sits beside the five-stage datapath as the single owner of all stall and flush decisions.

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/fetch_ctrl_if.sv | 50 +++++
 rtl/hazard_detect.sv | 26 ++
 rtl/fetch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared widths and FSM encodings for the fetch control unit
package fetch_ctrl_pkg;

    localparam int MEM_ADDR_WIDTH = 32;
    localparam int WORD_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        FC_RUN      = 2'd0,
        FC_REDIRECT = 2'd1,
        FC_SQUASH   = 2'd2,
        FC_MEM_WAIT = 2'd3
    } fc_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - control/status bundle between fetch_ctrl and the five-stage datapath
//
// master : fetch_ctrl view (drives stall/flush controls and statistics)
// slave  : datapath view (drives EX/ID/memory status, receives controls)
// Statistics outputs are always present; they read 0 unless
// FETCH_CTRL_STATS_EN is defined when building fetch_ctrl.
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int addr_width     = MEM_ADDR_WIDTH,
    parameter int reg_addr_width = REG_ADDR_WIDTH
);
    logic                      ex_bch_taken;
    logic [addr_width-1:0]     ex_bch_tgt;
    logic                      ex_is_load;
    logic [reg_addr_width-1:0] ex_rd;
    logic [reg_addr_width-1:0] id_rs1;
    logic [reg_addr_width-1:0] id_rs2;
    logic                      id_rs1_used;
    logic                      id_rs2_used;
    logic                      dmem_busy;

    logic                      pc_en;
    logic                      stall_en;
    logic                      jmp_bch_en;
    logic [addr_width-1:0]     jmp_bch_tgt;
    logic                      ifid_en;
    logic                      idex_bubble;
    logic                      pipe_freeze;

    logic [WORD_WIDTH-1:0]     stat_stall_cyc;
    logic [WORD_WIDTH-1:0]     stat_redirects;

    modport master (
        input  ex_bch_taken, ex_bch_tgt, ex_is_load, ex_rd,
               id_rs1, id_rs2, id_rs1_used, id_rs2_used, dmem_busy,
        output pc_en, stall_en, jmp_bch_en, jmp_bch_tgt,
               ifid_en, idex_bubble, pipe_freeze,
               stat_stall_cyc, stat_redirects
    );

    modport slave (
        output ex_bch_taken, ex_bch_tgt, ex_is_load, ex_rd,
               id_rs1, id_rs2, id_rs1_used, id_rs2_used, dmem_busy,
        input  pc_en, stall_en, jmp_bch_en, jmp_bch_tgt,
               ifid_en, idex_bubble, pipe_freeze,
               stat_stall_cyc, stat_redirects
    );

endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare
//
// Ports:
//   ex_is_load, ex_rd        : load in EX and its destination register
//   id_rs1/2, id_rs1/2_used  : ID source registers and whether each is read
//   lu_hazard                : ID consumes the result of the load in EX
module hazard_detect
    import fetch_ctrl_pkg::*;
#(
    parameter int reg_addr_width = REG_ADDR_WIDTH
) (
    input  logic                      ex_is_load,
    input  logic [reg_addr_width-1:0] ex_rd,
    input  logic [reg_addr_width-1:0] id_rs1,
    input  logic [reg_addr_width-1:0] id_rs2,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    output logic                      lu_hazard
);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign lu_hazard = ex_is_load && (ex_rd != '0) &&
                       ((id_rs1_used && (id_rs1 == ex_rd)) ||
                        (id_rs2_used && (id_rs2 == ex_rd)));

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - pipeline stall/flush controller for the fetch stage and IF/ID, ID/EX registers
//
// Single owner of stall and flush decisions: sequences branch redirects,
// wrong-path squashing, load-use bubbles and data-memory wait freezes.
// Priority: dmem_busy, then taken branch, then load-use hazard.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fetch_ctrl_if.master (EX/ID/memory status in, pipeline controls out)
//
// Optional build macro FETCH_CTRL_STATS_EN: enables the stall-cycle and
// redirect counters; without it both statistics outputs are tied to 0.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int addr_width     = MEM_ADDR_WIDTH,
    parameter int reg_addr_width = REG_ADDR_WIDTH,
    parameter int squash_depth   = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);

    localparam int cnt_w = (squash_depth > 1) ? $clog2(squash_depth) : 1;

    fc_state_t             state_q, state_d;
    fc_state_t             ret_q, ret_d;
    fc_state_t             eff_state;
    logic [addr_width-1:0] tgt_q, tgt_d;
    logic [cnt_w-1:0]      cnt_q, cnt_d;

    logic lu_hazard;
    logic branch_accept;
    logic pc_en_c, stall_en_c, jmp_en_c, ifid_en_c, bubble_c, freeze_c;

    hazard_detect #(
        .reg_addr_width (reg_addr_width)
    ) u_hazard_detect (
        .ex_is_load  (bus.ex_is_load),
        .ex_rd       (bus.ex_rd),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_rs1_used (bus.id_rs1_used),
        .id_rs2_used (bus.id_rs2_used),
        .lu_hazard   (lu_hazard)
    );

    // On the cycle memory releases, MEM_WAIT behaves exactly like the saved
    // state, so the resumed slot is not delayed by an extra cycle.
    assign eff_state = (state_q == FC_MEM_WAIT) ? ret_q : state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FC_RUN;
            ret_q   <= FC_RUN;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        tgt_d         = tgt_q;
        cnt_d         = cnt_q;
        branch_accept = 1'b0;
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        stall_en_c    = 1'b0;
        jmp_en_c      = 1'b0;
        bubble_c      = 1'b0;
        freeze_c      = 1'b0;

        if (bus.dmem_busy) begin
            // Whole pipe holds; a branch presented now is re-presented by EX later.
            pc_en_c   = 1'b0;
            ifid_en_c = 1'b0;
            freeze_c  = 1'b1;
            state_d   = FC_MEM_WAIT;
            if (state_q != FC_MEM_WAIT) begin
                ret_d = state_q;
            end
        end else begin
            state_d = eff_state;
            case (eff_state)
                FC_RUN: begin
                    if (bus.ex_bch_taken) begin
                        branch_accept = 1'b1;
                        tgt_d         = bus.ex_bch_tgt;
                        bubble_c      = 1'b1;
                        state_d       = FC_REDIRECT;
                    end else if (lu_hazard) begin
                        pc_en_c   = 1'b0;
                        ifid_en_c = 1'b0;
                        bubble_c  = 1'b1;
                    end
                end
                FC_REDIRECT: begin
                    jmp_en_c   = 1'b1;
                    stall_en_c = 1'b1;
                    cnt_d      = cnt_w'(squash_depth - 1);
                    state_d    = (squash_depth > 1) ? FC_SQUASH : FC_RUN;
                end
                FC_SQUASH: begin
                    stall_en_c = 1'b1;
                    cnt_d      = (cnt_q != '0) ? cnt_q - cnt_w'(1) : '0;
                    state_d    = (cnt_q <= cnt_w'(1)) ? FC_RUN : FC_SQUASH;
                end
                default: begin
                    state_d = FC_RUN;
                end
            endcase
        end

        // Reset wins immediately, abandoning any redirect in flight.
        if (rst) begin
            branch_accept = 1'b0;
            pc_en_c       = 1'b1;
            ifid_en_c     = 1'b1;
            stall_en_c    = 1'b0;
            jmp_en_c      = 1'b0;
            bubble_c      = 1'b0;
            freeze_c      = 1'b0;
        end
    end

    assign bus.pc_en       = pc_en_c;
    assign bus.ifid_en     = ifid_en_c;
    assign bus.stall_en    = stall_en_c;
    assign bus.jmp_bch_en  = jmp_en_c;
    assign bus.jmp_bch_tgt = tgt_q;
    assign bus.idex_bubble = bubble_c;
    assign bus.pipe_freeze = freeze_c;

`ifdef FETCH_CTRL_STATS_EN
    logic [WORD_WIDTH-1:0] stall_cyc_q;
    logic [WORD_WIDTH-1:0] redirects_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cyc_q <= '0;
            redirects_q <= '0;
        end else begin
            if (!pc_en_c) begin
                stall_cyc_q <= stall_cyc_q + 1'b1;
            end
            if (branch_accept) begin
                redirects_q <= redirects_q + 1'b1;
            end
        end
    end

    assign bus.stat_stall_cyc = stall_cyc_q;
    assign bus.stat_redirects = redirects_q;
`else
    assign bus.stat_stall_cyc = '0;
    assign bus.stat_redirects = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int AW = MEM_ADDR_WIDTH;
    localparam int RW = REG_ADDR_WIDTH;
    localparam int SD = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.addr_width(AW), .reg_addr_width(RW)) bus();

    fetch_ctrl #(
        .addr_width     (AW),
        .reg_addr_width (RW),
        .squash_depth   (SD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: slot = position inside a redirect window
    // (0 = normal flow, 1 = redirect cycle, 2..SD = squashed fetch slots).
    int            slot;
    logic [AW-1:0] m_tgt;
    int            m_stalls;
    int            m_redirs;

    // Output vector order: {pc_en, ifid_en, stall_en, jmp_bch_en, idex_bubble, pipe_freeze}
    localparam logic [5:0] RESET_OUT = 6'b110000;

    typedef struct {
        string      name;
        logic       is_load;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       busy;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [5:0] dut_out();
        return {bus.pc_en, bus.ifid_en, bus.stall_en, bus.jmp_bch_en,
                bus.idex_bubble, bus.pipe_freeze};
    endfunction

    task automatic model_reset();
        slot     = 0;
        m_tgt    = '0;
        m_stalls = 0;
        m_redirs = 0;
    endtask

    task automatic clear_inputs();
        bus.ex_bch_taken = 1'b0;
        bus.ex_bch_tgt   = '0;
        bus.ex_is_load   = 1'b0;
        bus.ex_rd        = '0;
        bus.id_rs1       = '0;
        bus.id_rs2       = '0;
        bus.id_rs1_used  = 1'b0;
        bus.id_rs2_used  = 1'b0;
        bus.dmem_busy    = 1'b0;
    endtask

    // Expected outputs for the current inputs, then advance the model one clock.
    task automatic model_cycle(output logic [5:0] e, output logic [AW-1:0] et);
        logic hz;
        et = m_tgt;
        hz = bus.ex_is_load && (bus.ex_rd != 0) &&
             ((bus.id_rs1_used && bus.id_rs1 == bus.ex_rd) ||
              (bus.id_rs2_used && bus.id_rs2 == bus.ex_rd));
        if (bus.dmem_busy) begin
            e = 6'b000001;
            m_stalls++;
        end else if (slot > 0) begin
            e    = {3'b111, (slot == 1), 2'b00};
            slot = (slot >= SD) ? 0 : slot + 1;
        end else if (bus.ex_bch_taken) begin
            e     = 6'b110010;
            m_tgt = bus.ex_bch_tgt;
            slot  = 1;
            m_redirs++;
        end else if (hz) begin
            e = 6'b000010;
            m_stalls++;
        end else begin
            e = 6'b110000;
        end
    endtask

    task automatic compare(string name, logic [5:0] e, logic [AW-1:0] et);
        checks++;
        if (dut_out() !== e || bus.jmp_bch_tgt !== et) begin
            errors++;
            $display("FAIL %s: got ctl=%b tgt=%h, required ctl=%b tgt=%h",
                     name, dut_out(), bus.jmp_bch_tgt, e, et);
        end
    endtask

    // One clock with inputs already applied: check against model, then advance.
    task automatic cycle(string name);
        logic [5:0]    e;
        logic [AW-1:0] et;
        @(negedge clk);
        model_cycle(e, et);
        compare(name, e, et);
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(string name, int exp_stall, int exp_redir);
        checks++;
        if (bus.stat_stall_cyc !== 32'(exp_stall) || bus.stat_redirects !== 32'(exp_redir)) begin
            errors++;
            $display("FAIL %s: got stall_cyc=%0d redirects=%0d, required %0d/%0d",
                     name, bus.stat_stall_cyc, bus.stat_redirects, exp_stall, exp_redir);
        end
    endtask

    initial begin
        logic [5:0]    e;
        logic [AW-1:0] et;

        vecs[0] = '{"lu_rs2",      1'b1, 5'd5,  5'd0,  5'd5,  1'b0, 1'b1, 1'b0, 6'b000010};
        vecs[1] = '{"lu_rd_zero",  1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 6'b110000};
        vecs[2] = '{"lu_rs1",      1'b1, 5'd7,  5'd7,  5'd3,  1'b1, 1'b0, 1'b0, 6'b000010};
        vecs[3] = '{"rs1_unused",  1'b1, 5'd7,  5'd7,  5'd3,  1'b0, 1'b1, 1'b0, 6'b110000};
        vecs[4] = '{"not_load",    1'b0, 5'd7,  5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 6'b110000};
        vecs[5] = '{"no_match",    1'b1, 5'd9,  5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 6'b110000};
        vecs[6] = '{"busy_over_lu",1'b1, 5'd5,  5'd0,  5'd5,  1'b0, 1'b1, 1'b1, 6'b000001};
        vecs[7] = '{"lu_r31",      1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 6'b000010};

        // Reset values
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare("reset_values", RESET_OUT, '0);
        check_stats("reset_stats", 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Free run, then a taken branch to 0x40 at cycle 5
        for (int i = 0; i < 5; i++) cycle("free_run");
        bus.ex_bch_taken = 1'b1;
        bus.ex_bch_tgt   = 32'h40;
        cycle("br_c5_bubble");
        bus.ex_bch_taken = 1'b0;
        bus.ex_bch_tgt   = 32'h1234;
        cycle("br_c6_redirect");
        cycle("br_c7_squash");
        cycle("br_c8_run");

        // Single-cycle combinational cases from RUN
        for (int i = 0; i < 8; i++) begin
            bus.ex_is_load  = vecs[i].is_load;
            bus.ex_rd       = vecs[i].rd;
            bus.id_rs1      = vecs[i].rs1;
            bus.id_rs2      = vecs[i].rs2;
            bus.id_rs1_used = vecs[i].u1;
            bus.id_rs2_used = vecs[i].u2;
            bus.dmem_busy   = vecs[i].busy;
            @(negedge clk);
            model_cycle(e, et);
            compare(vecs[i].name, vecs[i].exp, et);
            @(posedge clk);
            #1;
            clear_inputs();
            cycle("vec_recover");
        end

        // dmem_busy for 3 cycles entering SQUASH
        bus.ex_bch_taken = 1'b1;
        bus.ex_bch_tgt   = 32'h80;
        cycle("busy_sq_branch");
        bus.ex_bch_taken = 1'b0;
        cycle("busy_sq_redirect");
        bus.dmem_busy    = 1'b1;
        bus.ex_bch_taken = 1'b1;
        for (int i = 0; i < 3; i++) cycle("busy_sq_freeze");
        bus.dmem_busy    = 1'b0;
        bus.ex_bch_taken = 1'b0;
        cycle("busy_sq_resume_slot");
        cycle("busy_sq_run");

        // Reset pulsed the cycle after a taken branch
        bus.ex_bch_taken = 1'b1;
        bus.ex_bch_tgt   = 32'hC0;
        cycle("rst_branch");
        rst = 1'b1;
        model_reset();
        #1;
        compare("rst_mid_redirect", RESET_OUT, '0);
        @(negedge clk);
        compare("rst_hold_taken", RESET_OUT, '0);
        check_stats("rst_stats_clear", 0, 0);
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 1'b0;
        cycle("rst_after_release");
        cycle("rst_after_release2");

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bus.dmem_busy    = ($urandom_range(0, 99) < 12);
            bus.ex_bch_taken = ($urandom_range(0, 99) < 10);
            bus.ex_bch_tgt   = $urandom;
            bus.ex_is_load   = $urandom_range(0, 1);
            bus.ex_rd        = RW'($urandom_range(0, 3));
            bus.id_rs1       = RW'($urandom_range(0, 3));
            bus.id_rs2       = RW'($urandom_range(0, 3));
            bus.id_rs1_used  = $urandom_range(0, 1);
            bus.id_rs2_used  = $urandom_range(0, 1);
            cycle("random");
        end
        clear_inputs();
        cycle("final_idle");

        @(negedge clk);
`ifdef FETCH_CTRL_STATS_EN
        check_stats("stats_final", m_stalls, m_redirs);
`else
        check_stats("stats_tied_zero", 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
